// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 8-bit-PC core.
// Owns the PC register and an 8-entry absolute branch-target table. Each cycle it selects
// the next PC (hold, increment, table branch, halt) and runs a start/done handshake.
// Optional feature: define PC_LINK_EN to add a one-entry call/return link register.
module pc_sequencer #(
    parameter int unsigned  D        = 8,
    parameter int unsigned  IDX_W    = 3,
    parameter logic [D-1:0] START_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             branch,
    input  logic [IDX_W-1:0] br_idx,
    input  logic             halt_req,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [D-1:0]     cfg_data,
    input  logic             call,
    input  logic             ret,
    output logic [D-1:0]     prog_pc,
    output logic             running,
    output logic             done
);

    localparam int unsigned Depth = 2 ** IDX_W;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    // Power-on contents of the branch-target table; entries past index 7 reset to zero.
    function automatic logic [D-1:0] table_rst_val(input int unsigned idx);
        case (idx)
            0:       return D'(17);
            1:       return D'(22);
            2:       return D'(24);
            3:       return D'(31);
            4:       return D'(35);
            5:       return D'(44);
            6:       return D'(46);
            7:       return D'(64);
            default: return '0;
        endcase
    endfunction

    state_e       r_state, w_state_d;
    logic [D-1:0] r_pc, w_pc_d;
    logic         r_running, r_done;
    logic [D-1:0] r_table [Depth];
    logic [D-1:0] w_target;
    logic [D-1:0] w_pc_inc;

    // Old table contents are read here, so a same-cycle write is seen only by later branches.
    assign w_target = r_table[br_idx];
    assign w_pc_inc = r_pc + D'(1);

`ifdef PC_LINK_EN
    logic [D-1:0] r_link, w_link_d;

    // Link register: holds the return address of the most recent call.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_link <= '0;
        end else begin
            r_link <= w_link_d;
        end
    end
`else
    logic w_unused_link;
    assign w_unused_link = call ^ ret;
`endif

    // Branch-target table: writable in any state, stall does not block writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_table[i] <= table_rst_val(i);
            end
        end else if (cfg_we) begin
            r_table[cfg_idx] <= cfg_data;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
`ifdef PC_LINK_EN
        w_link_d  = r_link;
`endif
        unique case (r_state)
            StIdle: begin
                w_pc_d = START_PC;
                if (start) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (stall) begin
                    // Freeze everything; control inputs are dropped for this cycle.
                end else if (halt_req) begin
                    w_state_d = StHalt;
                end else begin
`ifdef PC_LINK_EN
                    if (ret) begin
                        w_pc_d = r_link;
                    end else if (call) begin
                        w_link_d = w_pc_inc;
                        w_pc_d   = w_target;
                    end else if (branch) begin
                        w_pc_d = w_target;
                    end else begin
                        w_pc_d = w_pc_inc;
                    end
`else
                    if (branch) begin
                        w_pc_d = w_target;
                    end else begin
                        w_pc_d = w_pc_inc;
                    end
`endif
                end
            end
            StHalt: begin
                if (start) begin
                    w_state_d = StRun;
                    w_pc_d    = START_PC;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_pc_d    = START_PC;
            end
        endcase
    end

    // State, PC and status flags; flags are registered so outputs never see input paths.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_pc      <= START_PC;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pc      <= w_pc_d;
            r_running <= (w_state_d == StRun);
            r_done    <= (w_state_d == StHalt);
        end
    end

    assign prog_pc = r_pc;
    assign running = r_running;
    assign done    = r_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expectations are queued as each cycle's stimulus is
// driven and compared one cycle later against {running, done, prog_pc}.
module tb_pc_sequencer;

`ifdef PC_LINK_EN
    localparam bit Link = 1'b1;
`else
    localparam bit Link = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stall, branch, halt_req, cfg_we, call, ret;
    logic [2:0] br_idx, cfg_idx;
    logic [7:0] cfg_data;
    logic [7:0] prog_pc;
    logic       running, done;

    int errors = 0;
    int checks = 0;

    string      tag_q[$];
    logic [9:0] exp_q[$];

    pc_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stall    (stall),
        .branch   (branch),
        .br_idx   (br_idx),
        .halt_req (halt_req),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_data (cfg_data),
        .call     (call),
        .ret      (ret),
        .prog_pc  (prog_pc),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        start    = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        br_idx   = 3'd0;
        halt_req = 1'b0;
        cfg_we   = 1'b0;
        cfg_idx  = 3'd0;
        cfg_data = 8'd0;
        call     = 1'b0;
        ret      = 1'b0;
    endtask

    // Queue the expected post-edge outputs, clock once, then return inputs to idle.
    task automatic tick(input string tag, input int unsigned pc, input logic run,
                        input logic dn);
        tag_q.push_back(tag);
        exp_q.push_back({run, dn, 8'(pc)});
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    // Scoreboard monitor: compares outputs 1 time unit after each rising edge.
    always @(posedge clk) begin : monitor
        string      t;
        logic [9:0] e;
        #1;
        if (exp_q.size() != 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, {22'd0, running, done, prog_pc}, {22'd0, e});
        end
    end

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset", {22'd0, running, done, prog_pc}, 32'd0);
        reset_n = 1'b1;

        tick("idle_hold", 0, 0, 0);
        start = 1'b1;
        tick("start", 0, 1, 0);
        for (int i = 1; i <= 5; i++) tick("count", i, 1, 0);

        branch = 1'b1; br_idx = 3'd4; tick("br_idx4", 35, 1, 0);
        branch = 1'b1; br_idx = 3'd7; tick("br_idx7", 64, 1, 0);
        tick("inc_after_br", 65, 1, 0);
        tick("inc_after_br", 66, 1, 0);

        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; branch = 1'b1; halt_req = 1'b1; br_idx = 3'd0;
            tick("stall_hold", 66, 1, 0);
        end
        branch = 1'b1; br_idx = 3'd0; tick("unstall_br0", 17, 1, 0);

        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_data = 8'd200; branch = 1'b1; br_idx = 3'd2;
        tick("rbw_old", 24, 1, 0);
        tick("inc_25", 25, 1, 0);
        branch = 1'b1; br_idx = 3'd2; tick("br_new200", 200, 1, 0);

        stall = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd3; cfg_data = 8'd255;
        tick("stall_cfg", 200, 1, 0);
        cfg_we = 1'b1; cfg_idx = 3'd6; cfg_data = 8'd40; tick("cfg_only", 201, 1, 0);
        branch = 1'b1; br_idx = 3'd6; tick("br_to40", 40, 1, 0);

        halt_req = 1'b1; tick("halt", 40, 0, 1);
        branch = 1'b1; br_idx = 3'd0; tick("halt_hold", 40, 0, 1);
        tick("halt_hold", 40, 0, 1);
        start = 1'b1; tick("restart", 0, 1, 0);

        branch = 1'b1; br_idx = 3'd3; tick("br_to255", 255, 1, 0);
        tick("wrap", 0, 1, 0);
        tick("after_wrap", 1, 1, 0);
        start = 1'b1; tick("start_in_run", 2, 1, 0);

        cfg_we = 1'b1; cfg_idx = 3'd4; cfg_data = 8'd10; tick("cfg4", 3, 1, 0);
        branch = 1'b1; br_idx = 3'd4; tick("br_to10", 10, 1, 0);
        call = 1'b1; br_idx = 3'd1; tick("call", Link ? 22 : 11, 1, 0);
        tick("after_call", Link ? 23 : 12, 1, 0);
        ret = 1'b1; tick("ret", Link ? 11 : 13, 1, 0);
        call = 1'b1; ret = 1'b1; br_idx = 3'd5; tick("ret_over_call", Link ? 11 : 14, 1, 0);

        // Asynchronous reset mid-run, sampled before any further clock edge.
        reset_n = 1'b0;
        #1;
        check("async_reset", {22'd0, running, done, prog_pc}, 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        start = 1'b1; tick("start2", 0, 1, 0);
        ret = 1'b1; tick("ret_link_rst", Link ? 0 : 1, 1, 0);
        branch = 1'b1; br_idx = 3'd2; tick("table_rst", 24, 1, 0);
        halt_req = 1'b1; tick("halt2", 24, 0, 1);

        @(posedge clk);
        #2;
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the 8-bit-PC core.
- Owns the PC register and a programmable 8-entry absolute branch-target table.
- Each cycle it selects the next PC: hold, increment, table branch, or halt.
- Runs a start/done handshake with the top-level test harness.

Parameters:
- D, 8, PC and branch-target width in bits.
- IDX_W, 3, branch-index width; the table has 2**IDX_W entries.
- START_PC, 0, PC value loaded when execution starts.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level; starts execution from IDLE or HALT.
- stall  input  1  freezes the PC and state for the current cycle.
- branch  input  1  taken absolute branch this cycle.
- br_idx  input  IDX_W  branch-target table index.
- halt_req  input  1  halt instruction decoded this cycle.
- cfg_we  input  1  table write enable.
- cfg_idx  input  IDX_W  table write index.
- cfg_data  input  D  table write data.
- call  input  1  subroutine call; used only with PC_LINK_EN.
- ret  input  1  subroutine return; used only with PC_LINK_EN.
- prog_pc  output  D  current PC, used as the instruction-memory address.
- running  output  1  high while in RUN.
- done  output  1  high while in HALT.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values:
  - state = IDLE, prog_pc = START_PC, running = 0, done = 0.
  - Table contents by index 0..7: 17, 22, 24, 31, 35, 44, 46, 64.
  - Link register = 0.
  - Reset asserted mid-run forces these values immediately, independent of clk.
- All outputs are registered, with no combinational paths from inputs.
- States:
  - IDLE: prog_pc held at START_PC. start = 1 -> RUN; prog_pc stays START_PC for the first RUN cycle.
  - RUN: one PC update per unstalled cycle. Priority, highest first:
    1. stall: hold everything. halt_req, branch, call and ret are ignored that cycle.
    2. halt_req: go to HALT, prog_pc unchanged, done = 1 on the next cycle.
    3. ret (PC_LINK_EN only).
    4. call (PC_LINK_EN only).
    5. branch: prog_pc = table[br_idx].
    6. Otherwise: prog_pc = prog_pc + 1, modulo 2**D.
  - HALT: prog_pc and done held. start = 1 -> RUN with prog_pc = START_PC and done = 0 on the next cycle.
- Wrap-around: in RUN, PC 2**D-1 increments to 0. There is no flag and no auto-halt.
- Table is absolute: a branch target replaces the PC and is never added to it.
- Table writes:
  - Accepted in any state, including while stall is high.
  - A write takes effect at the clock edge.
  - If a branch reads the same index in the same cycle, the branch uses the old value (read-before-write).
- start while already in RUN is ignored.
- running and done are never high together.

Optional Feature:
- Macro: PC_LINK_EN.
- Defined: adds a one-entry link register of width D.
  - call in RUN, unstalled: link = prog_pc + 1 (mod 2**D), prog_pc = table[br_idx].
  - ret: prog_pc = link.
  - ret has priority over call, and call over branch.
  - A call while the link register is valid overwrites it; there is no stack.
- Undefined: the call and ret ports exist but are ignored, and the link register is not synthesized.

Test Plan:
- Reset and start: assert reset_n = 0 -> prog_pc = 0, running = 0, done = 0. Release, pulse start -> running = 1, then prog_pc counts 0, 1, 2, 3 on successive cycles.
- Branch table: at PC 5, branch = 1, br_idx = 4 -> next prog_pc = 35. br_idx = 7 -> 64. Then increment resumes: 65, 66.
- Stall priority: stall = 1 together with branch = 1 and halt_req = 1 for 3 cycles -> prog_pc and state frozen. Drop stall with branch still high, br_idx = 0 -> prog_pc = 17.
- Config collision: cfg_we = 1, cfg_idx = 2, cfg_data = 200, with branch br_idx = 2 in the same cycle -> prog_pc = 24. A later branch to index 2 -> 200.
- Halt and restart, plus wrap: halt_req at PC 40 -> done = 1, prog_pc holds 40 while start = 0. start -> prog_pc = 0, done = 0. Branch to a 255 target, then increment -> 0.
- PC_LINK_EN: call with br_idx = 1 at PC 10 -> prog_pc = 22, link = 11. ret later -> prog_pc = 11. Assert reset_n = 0 mid-run -> link = 0 and prog_pc = 0 immediately.
